// File: rtl/position_mover.sv
// Frame-paced sprite position mover: steps the displayed cell one unit per
// axis toward the position captured on each frame tick.
module position_mover #(
  parameter int X_BITS          = 6,
  parameter int Y_BITS          = 6,
  parameter int FRAMES_PER_STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [X_BITS+Y_BITS-1:0] pos_in,
  input  logic                     frame_tick,
  input  logic                     snap,
  input  logic                     enable,
  output logic [X_BITS-1:0]        cur_x,
  output logic [Y_BITS-1:0]        cur_y,
  output logic                     moving,
  output logic                     arrived
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MOVE = 1'b1;
  localparam logic [7:0] LAST   = 8'(FRAMES_PER_STEP - 1);

  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [7:0]        r_cnt;
  logic [0:0]        r_state;
  logic              r_arrived;

  logic [X_BITS-1:0] w_tx;
  logic [Y_BITS-1:0] w_ty;
  logic [X_BITS-1:0] w_nx;
  logic [Y_BITS-1:0] w_ny;
  logic              w_same;
  logic              w_hit;

  // Target is the word present on the tick edge itself.
  assign w_tx = pos_in[X_BITS-1:0];
  assign w_ty = pos_in[X_BITS+:Y_BITS];

  // Compare-guarded steps can never overshoot or wrap.
  always_comb begin
    w_nx = r_x;
    if (r_x < w_tx) begin
      w_nx = r_x + 1'b1;
    end else if (r_x > w_tx) begin
      w_nx = r_x - 1'b1;
    end
  end

  always_comb begin
    w_ny = r_y;
    if (r_y < w_ty) begin
      w_ny = r_y + 1'b1;
    end else if (r_y > w_ty) begin
      w_ny = r_y - 1'b1;
    end
  end

  assign w_same = (w_tx == r_x) && (w_ty == r_y);
  assign w_hit  = (w_tx == w_nx) && (w_ty == w_ny);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_state   <= S_IDLE;
      r_arrived <= 1'b0;
    end else begin
      r_arrived <= 1'b0;
      if (frame_tick) begin
        if (snap) begin
          r_x       <= w_tx;
          r_y       <= w_ty;
          r_cnt     <= '0;
          r_state   <= S_IDLE;
          r_arrived <= !w_same;
        end else if (r_state == S_IDLE) begin
          r_cnt <= '0;
          if (!w_same) begin
            r_state <= S_MOVE;
          end
        end else if (w_same) begin
          r_cnt     <= '0;
          r_state   <= S_IDLE;
          r_arrived <= 1'b1;
        end else if (enable) begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_x   <= w_nx;
            r_y   <= w_ny;
            if (w_hit) begin
              r_state   <= S_IDLE;
              r_arrived <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign cur_x   = r_x;
  assign cur_y   = r_y;
  assign moving  = (r_state == S_MOVE);
  assign arrived = r_arrived;

endmodule
